// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative 32x32 multiply/divide unit with HI/LO registers
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   request strobe, sampled only while busy=0
//   op     in   3   0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO 6/7=no-op
//   a      in  32   operand A / dividend / MTHI-MTLO source
//   b      in  32   operand B / divisor
//   busy   out  1   iterative operation in progress (RUN or FIX)
//   done   out  1   one-cycle pulse, hi/lo hold the new result
//   hi     out 32   HI register
//   lo     out 32   LO register
//
// Build option: define MULDIV_DIV_EN to include the divide datapath.
// Without it DIV/DIVU are decoded as no-ops.

module muldiv_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
`endif
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4:0]  cnt;
  // Shared working register: multiply keeps {partial_product_hi, multiplier},
  // divide keeps {partial_remainder, dividend/quotient}. Both shift one bit
  // per RUN cycle, so the same 64 flops serve both operations.
  logic [63:0] acc;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [31:0] opnd;
  // Negate the product / quotient in FIX.
  logic        neg_main;
`ifdef MULDIV_DIV_EN
  logic        neg_rem;
  logic        is_div;
  logic        divz;
`endif

  // ---------------------------------------------------------------- decode
  logic op_iter;
  logic op_signed;
`ifdef MULDIV_DIV_EN
  logic op_is_div;
`endif

  always_comb begin
    op_iter   = 1'b0;
    op_signed = 1'b0;
`ifdef MULDIV_DIV_EN
    op_is_div = 1'b0;
`endif
    case (op)
      OP_MULTU: op_iter = 1'b1;
      OP_MULT: begin
        op_iter   = 1'b1;
        op_signed = 1'b1;
      end
`ifdef MULDIV_DIV_EN
      OP_DIVU: begin
        op_iter   = 1'b1;
        op_is_div = 1'b1;
      end
      OP_DIV: begin
        op_iter   = 1'b1;
        op_is_div = 1'b1;
        op_signed = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Signed ops run on magnitudes; signs are restored in FIX.
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  assign a_mag = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (op_signed && b[31]) ? (~b + 32'd1) : b;

  // ------------------------------------------------------ multiply step
  // Add the multiplicand into the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right. The 33rd sum bit
  // becomes the new MSB, so no carry is lost.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // ------------------------------------------------------- divide step
`ifdef MULDIV_DIV_EN
  // Restoring division: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the outcome bit into the
  // quotient. When the subtraction fits, the difference is below the
  // divisor, so the 32-bit wrapped subtraction is exact.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[31:0] - opnd;
  assign div_next  = {(div_ge ? div_sub : div_shift[31:0]), acc[30:0], div_ge};

  // A zero divisor leaves |a| in the remainder and all-ones in the quotient;
  // restoring the dividend sign on the remainder therefore yields raw a.
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign quo_fix = neg_main ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
`endif

  logic [63:0] prod_fix;
  assign prod_fix = neg_main ? (~acc + 64'd1) : acc;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && op_iter) state_nx = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg_main <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      divz     <= 1'b0;
`endif
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_iter) begin
              cnt      <= 5'd0;
              acc      <= {32'd0, a_mag};
              opnd     <= b_mag;
              neg_main <= op_signed & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
              neg_rem  <= op_signed & a[31];
              is_div   <= op_is_div;
              divz     <= (b == 32'd0);
`endif
            end else if (op == OP_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
        end
        S_FIX: begin
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            hi <= rem_fix;
            lo <= divz ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
`else
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
`endif
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - bench for muldiv_hilo against an arithmetic reference model

module tb_muldiv_hilo;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_hilo dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: results from plain 64-bit arithmetic, plus the
  // externally visible timing (busy cycles, done cycle) for the op class.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int exp_busy, output int exp_done);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    exp_busy = 0;
    exp_done = 0;
    case (o)
      3'd0: begin
        p = {32'd0, x} * {32'd0, y};
        m_hi = p[63:32]; m_lo = p[31:0];
        exp_busy = 33; exp_done = 34;
      end
      3'd1: begin
        p = sx * sy;
        m_hi = p[63:32]; m_lo = p[31:0];
        exp_busy = 33; exp_done = 34;
      end
`ifdef MULDIV_DIV_EN
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          m_hi = x % y; m_lo = x / y;
        end else begin
          q = sx / sy; r = sx % sy;
          m_hi = r[31:0]; m_lo = q[31:0];
        end
        exp_busy = 33; exp_done = 34;
      end
`endif
      3'd4: begin m_hi = x; exp_done = 1; end
      3'd5: begin m_lo = x; exp_done = 1; end
      default: ;
    endcase
  endtask

  // Issue one request and watch 40 cycles. poke>0 re-pulses start with a
  // different MULTU request in that cycle, which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int poke);
    int exp_busy, exp_done, bcnt, dcyc, dcnt;
    logic [31:0] ghi, glo;
    model(o, x, y, exp_busy, exp_done);
    bcnt = 0; dcyc = 0; dcnt = 0; ghi = 32'd0; glo = 32'd0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke > 0 && k == poke) begin
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcyc == 0) begin
          dcyc = k; ghi = hi; glo = lo;
          chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
      end
    end
    if (dcyc == 0) begin ghi = hi; glo = lo; end
    chk({tag, "_busy_cycles"}, bcnt, exp_busy);
    chk({tag, "_done_cycle"}, dcyc, exp_done);
    chk({tag, "_done_count"}, dcnt, (exp_done != 0) ? 1 : 0);
    chk({tag, "_hi"}, ghi, m_hi);
    chk({tag, "_lo"}, glo, m_lo);
  endtask

  initial begin
    int dc;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    n_tests = 0; n_fail = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    do_op("multu_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_ff_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_ff_lo_const", lo, 32'h0000_0001);

    do_op("mult_m7x3", 3'd1, 32'hFFFF_FFF9, 32'd3, 0);
    chk("mult_m7x3_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_m7x3_lo_const", lo, 32'hFFFF_FFEB);

    do_op("multu_zero", 3'd0, 32'd0, 32'h1234_5678, 0);
    do_op("mult_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);

    do_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
`ifdef MULDIV_DIV_EN
    chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
`endif
    do_op("divu_100_7", 3'd2, 32'd100, 32'd7, 0);
`ifdef MULDIV_DIV_EN
    chk("divu_100_7_lo_const", lo, 32'd14);
    chk("divu_100_7_hi_const", hi, 32'd2);
`endif
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("divu_by0", 3'd2, 32'h1234, 32'd0, 0);
    do_op("div_by0_neg", 3'd3, 32'h8765_4321, 32'd0, 0);

    do_op("mthi", 3'd4, 32'hDEAD_BEEF, 32'd0, 0);
    do_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 0);
    chk("mthi_const", hi, 32'hDEAD_BEEF);
    chk("mtlo_const", lo, 32'hCAFE_F00D);
    do_op("nop6", 3'd6, 32'h1111_1111, 32'h2222_2222, 0);
    do_op("nop7", 3'd7, 32'h3333_3333, 32'h4444_4444, 0);

    do_op("multu_poke", 3'd0, 32'h0001_0003, 32'h0000_0105, 5);

    // Abort a MULT with reset in cycle N+10.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hFFFF_0001; b = 32'h0000_7777;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort_no_done", dc, 0);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
      do_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the integer ALU in the execute stage. Takes the same 32-bit register-file operands as the ALU and produces 64-bit products and quotient/remainder pairs over 34 cycles, freeing the ALU from wide combinational multiply. The pipeline control stalls on `busy`; the MFHI/MFLO path reads `hi`/`lo` directly.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6/7=no-op.
- `a`  in  32  operand A / dividend / MTxx source.
- `b`  in  32  operand B / divisor.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result in that cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset (`rst`=1 at an edge, whatever the state): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, iteration counter=0.
- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - MULT/MULTU/DIV/DIVU: latch operands and go to RUN with counter=0.
  - Signed ops latch magnitudes `|a|`, `|b|`.
  - Latch sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31]. Both are 0 for unsigned ops.
- IDLE, `start`=1, MTHI/MTLO: `hi`<=a or `lo`<=a at this edge; state stays IDLE; `done`=1 the next cycle.
- IDLE, `start`=1, op 6/7: ignored, no `done`.
- RUN: one iteration per cycle for 32 cycles. Counter increments, 0..31; at 31 go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX:
  - Apply sign correction: two's-complement negate of the 64-bit product, the quotient and/or the remainder per the latched flags.
  - Write `hi` (product[63:32] or remainder) and `lo` (product[31:0] or quotient).
  - Go to IDLE; `done`=1 the following cycle.
- Divide by zero (b=0): HI=a (raw input), LO=32'hFFFF_FFFF for DIV and DIVU. No trap.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (natural wrap).
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `hi`/`lo` change only on FIX, MTHI/MTLO, or reset. A failed or ignored request leaves them untouched.

## Timing
- Iterative op: `start` sampled at edge N (cycle N).
  - `busy`=1 in cycles N+1..N+33 (32 RUN + 1 FIX).
  - `hi`/`lo` updated at the end of cycle N+33.
  - `done`=1 and `busy`=0 in cycle N+34.
- A new `start` is accepted in cycle N+34 (same cycle as `done`).
- MTHI/MTLO: register visible and `done`=1 in cycle N+1; `busy` never asserts.
- `done` is registered, never combinational from `start`.
- Reset asserted in any RUN/FIX cycle aborts: next cycle is IDLE with all outputs 0, and no `done` for the aborted op.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU implemented as above.
- `MULDIV_DIV_EN` undefined: the divide datapath is compiled out.
  - DIV/DIVU are treated as no-ops: ignored in IDLE, no `busy`, no `done`, `hi`/`lo` unchanged.
  - MULT/MULTU/MTHI/MTLO behave identically in both builds.

## Test plan
- Reset then MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → `busy` high for exactly 33 cycles; `done` in cycle N+34; hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- MULT a=-7 (32'hFFFF_FFF9), b=3 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then MULTU 0×12345678 → hi=lo=0.
- DIV a=-7, b=2 → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU 100/7 → lo=14, hi=2. DIV 32'h8000_0000/-1 → lo=32'h8000_0000, hi=0.
- DIVU a=32'h1234, b=0 → hi=32'h1234, lo=32'hFFFF_FFFF.
- MTHI a=32'hDEAD_BEEF then MTLO a=32'hCAFE_F00D → each `done` 1 cycle later, `busy` stays 0. Then `start` with MULTU pulsed again at cycle N+5 → ignored, and the result equals the first request's operands.
- Assert `rst` at cycle N+10 of a MULT → cycle N+11: busy=0, done=0, hi=lo=0, and no `done` follows. Without `MULDIV_DIV_EN`, DIVU 100/7 → no `busy`/`done`, `hi`/`lo` unchanged.
